// File: rtl/memory_ctrl_if.sv
// Command/response bundle for memory_ctrl.
// The master issues commands; the slave answers with done/err/rd_data.
interface memory_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rd_data, done, err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rd_data, done, err, busy
  );
endinterface

// File: rtl/memory_ctrl.sv
// Single-port RAM controller: read/write plus multi-cycle clear/fill sweeps.
// One command in flight; completion reported by a registered done/err pulse.
module memory_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input logic clk,
  input logic rst_n,
  memory_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_SWEEP  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;
  localparam logic [2:0] OP_FILL  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [2:0]        state, nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] cnt;
  logic              err_pend;
  logic [DATA_W-1:0] rd_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic is_rw, is_sw, dec_err, accept;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  always_comb begin
    is_rw = 1'b0;
    is_sw = 1'b0;
    unique case (1'b1)
      (op_q == OP_READ),
      (op_q == OP_WRITE): is_rw = 1'b1;
      (op_q == OP_CLEAR),
      (op_q == OP_FILL):  is_sw = 1'b1;
      default:            ;
    endcase
  end

  assign dec_err = !(is_rw || is_sw)
                || (is_rw && 32'(addr_q) >= DEPTH);
  assign accept  = (state == S_IDLE) && bus.cmd_valid
                && (bus.cmd_op != 3'd0);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (accept) nxt = S_DECODE;
      S_DECODE: begin
        if (dec_err)    nxt = S_RESP;
        else if (is_rw) nxt = S_EXEC;
        else            nxt = S_SWEEP;
      end
      S_EXEC:   nxt = S_RESP;
      S_SWEEP:  if (cnt == LAST) nxt = S_RESP;
      S_RESP:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state  <= nxt;
      busy_q <= (nxt != S_IDLE);
      done_q <= (nxt == S_RESP);
      err_q  <= (nxt == S_RESP)
             && (err_pend || (state == S_DECODE && dec_err));
      if (accept) begin
        op_q    <= bus.cmd_op;
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
      end
      if (state == S_DECODE) begin
        cnt      <= '0;
        err_pend <= dec_err;
      end
      if (state == S_SWEEP && cnt != LAST)
        cnt <= cnt + 1'b1;
      if (state == S_EXEC && op_q == OP_READ)
        rd_q <= mem[addr_q];
      if (state == S_RESP)
        err_pend <= 1'b0;
    end
  end

  // Storage has no reset: an interrupted sweep leaves it partially written.
  assign we = (state == S_SWEEP)
           || (state == S_EXEC && op_q == OP_WRITE);
  assign wa = (state == S_SWEEP) ? cnt : addr_q;
  assign wd = (state == S_SWEEP && op_q == OP_CLEAR) ? '0 : wdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_data   = rd_q;
endmodule

// File: tb/tb_memory_ctrl.sv
// Bench for memory_ctrl: vector table, corner sequences, random vs model.
// Second instance covers a wider, non-power-of-two configuration.
module tb_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_ctrl_if #(.DATA_W(16), .ADDR_W(5)) bus0 ();
  memory_ctrl_if #(.DATA_W(32), .ADDR_W(6)) bus1 ();

  memory_ctrl #(.DATA_W(16), .ADDR_W(5), .DEPTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  memory_ctrl #(.DATA_W(32), .ADDR_W(6), .DEPTH(40)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int tot = 0;
  int bad = 0;

  logic [15:0] mem_m [16];
  logic [15:0] rd_m;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  a;
    logic [15:0] d;
    bit          e;
    int          lat;
    logic [15:0] rd;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      tot++;
      if (bus0.busy === bus0.cmd_ready
          || (bus0.err && !bus0.done)) begin
        bad++;
        $display("FAIL inv: busy=%b ready=%b done=%b err=%b",
                 bus0.busy, bus0.cmd_ready, bus0.done, bus0.err);
      end
    end
  end

  task automatic model(input logic [2:0] op, input logic [4:0] a,
                       input logic [15:0] d,
                       output bit e, output int lat);
    e = 1'b0;
    if (op >= 3'd5 || ((op == 3'd1 || op == 3'd2) && a >= 16)) begin
      e = 1'b1;
      lat = 2;
    end else if (op == 3'd1) begin
      rd_m = mem_m[a[3:0]];
      lat = 3;
    end else if (op == 3'd2) begin
      mem_m[a[3:0]] = d;
      lat = 3;
    end else begin
      for (int i = 0; i < 16; i++)
        mem_m[i] = (op == 3'd3) ? 16'h0 : d;
      lat = 18;
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [4:0] a,
                     input logic [15:0] d,
                     output int lat, output bit e);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus0.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tot++; bad++;
      $display("FAIL ready_wait: got busy want ready");
    end
    bus0.cmd_valid = 1'b1;
    bus0.cmd_op    = op;
    bus0.cmd_addr  = a;
    bus0.cmd_wdata = d;
    @(posedge clk);
    #1;
    bus0.cmd_valid = 1'b0;
    bus0.cmd_op    = 3'($urandom);
    bus0.cmd_addr  = 5'($urandom);
    bus0.cmd_wdata = 16'($urandom);
    lat = 0;
    e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus0.done) begin
        lat = i;
        e = bus0.err;
        break;
      end
    end
    if (lat == 0) begin
      tot++; bad++;
      $display("FAIL done_wait: got no done want done");
    end
  endtask

  task automatic run1(input logic [2:0] op, input logic [5:0] a,
                      input logic [31:0] d,
                      output int lat, output bit e);
    @(negedge clk);
    bus1.cmd_valid = 1'b1;
    bus1.cmd_op    = op;
    bus1.cmd_addr  = a;
    bus1.cmd_wdata = d;
    @(posedge clk);
    #1;
    bus1.cmd_valid = 1'b0;
    lat = 0;
    e = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus1.done) begin
        lat = i;
        e = bus1.err;
        break;
      end
    end
  endtask

  task automatic check_cmd(string nm, logic [2:0] op, logic [4:0] a,
                           logic [15:0] d);
    bit e, ge;
    int l, gl;
    model(op, a, d, e, l);
    run(op, a, d, gl, ge);
    chk({nm, "_lat"}, gl, l);
    chk({nm, "_err"}, 32'(ge), 32'(e));
    chk({nm, "_rd"}, bus0.rd_data, rd_m);
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(bus0.done), 0);
  endtask

  initial begin
    bit  e, ge;
    int  l, gl, n;

    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0;
    rd_m = 16'h0;
    bus0.cmd_valid = 1'b0; bus0.cmd_op = '0;
    bus0.cmd_addr = '0;    bus0.cmd_wdata = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = '0;
    bus1.cmd_addr = '0;    bus1.cmd_wdata = '0;

    tbl[0]  = '{3'd2, 5'd3,  16'hBEEF, 1'b0, 3,  16'h0000};
    tbl[1]  = '{3'd1, 5'd3,  16'h0000, 1'b0, 3,  16'hBEEF};
    tbl[2]  = '{3'd4, 5'd0,  16'hA5A5, 1'b0, 18, 16'hBEEF};
    tbl[3]  = '{3'd1, 5'd0,  16'h0000, 1'b0, 3,  16'hA5A5};
    tbl[4]  = '{3'd1, 5'd15, 16'h0000, 1'b0, 3,  16'hA5A5};
    tbl[5]  = '{3'd3, 5'd9,  16'h5555, 1'b0, 18, 16'hA5A5};
    tbl[6]  = '{3'd1, 5'd7,  16'h0000, 1'b0, 3,  16'h0000};
    tbl[7]  = '{3'd2, 5'd3,  16'h1234, 1'b0, 3,  16'h0000};
    tbl[8]  = '{3'd6, 5'd3,  16'h9999, 1'b1, 2,  16'h0000};
    tbl[9]  = '{3'd2, 5'd20, 16'h7777, 1'b1, 2,  16'h0000};
    tbl[10] = '{3'd1, 5'd3,  16'h0000, 1'b0, 3,  16'h1234};
    tbl[11] = '{3'd1, 5'd20, 16'h0000, 1'b1, 2,  16'h1234};

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus0.cmd_ready), 1);
    chk("rst_busy",  32'(bus0.busy), 0);
    chk("rst_done",  32'(bus0.done), 0);
    chk("rst_err",   32'(bus0.err), 0);
    chk("rst_rd",    bus0.rd_data, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      model(tbl[i].op, tbl[i].a, tbl[i].d, e, l);
      run(tbl[i].op, tbl[i].a, tbl[i].d, gl, ge);
      chk($sformatf("vec%0d_lat", i), gl, tbl[i].lat);
      chk($sformatf("vec%0d_err", i), 32'(ge), 32'(tbl[i].e));
      chk($sformatf("vec%0d_rd", i), bus0.rd_data, tbl[i].rd);
    end

    // NOP held valid: nothing should happen.
    @(negedge clk);
    bus0.cmd_valid = 1'b1;
    bus0.cmd_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nop_done", 32'(bus0.done), 0);
      chk("nop_busy", 32'(bus0.busy), 0);
    end

    // READ held valid: re-accept only after the IDLE cycle following RESP.
    bus0.cmd_op = 3'd1;
    bus0.cmd_addr = 5'd3;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus0.done) begin
        n = i;
        break;
      end
    end
    chk("hold_lat", n, 3);
    rd_m = mem_m[3];
    chk("hold_rd", bus0.rd_data, rd_m);
    @(negedge clk);
    chk("hold_idle_ready", 32'(bus0.cmd_ready), 1);
    @(negedge clk);
    chk("hold_reaccept", 32'(bus0.busy), 1);
    bus0.cmd_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus0.done) begin
        n = i;
        break;
      end
    end
    chk("hold2_lat", n, 2);

    // Reset in the middle of a FILL sweep.
    check_cmd("pre_w10", 3'd2, 5'd10, 16'h0A0A);
    @(negedge clk);
    bus0.cmd_valid = 1'b1;
    bus0.cmd_op = 3'd4;
    bus0.cmd_wdata = 16'hFFFF;
    @(posedge clk);
    #1;
    bus0.cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_busy",  32'(bus0.busy), 0);
    chk("mid_ready", 32'(bus0.cmd_ready), 1);
    chk("mid_done",  32'(bus0.done), 0);
    chk("mid_rd",    bus0.rd_data, 0);
    for (int i = 0; i < 6; i++) mem_m[i] = 16'hFFFF;
    rd_m = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_cmd("post_r0",  3'd1, 5'd0,  16'h0);
    check_cmd("post_r5",  3'd1, 5'd5,  16'h0);
    check_cmd("post_r6",  3'd1, 5'd6,  16'h0);
    check_cmd("post_r10", 3'd1, 5'd10, 16'h0);

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      check_cmd($sformatf("rnd%0d", i),
                3'($urandom_range(1, 7)),
                5'($urandom_range(0, 31)),
                16'($urandom));
    end

    // Wide / non-power-of-two instance.
    run1(3'd2, 6'd39, 32'hDEADBEEF, gl, ge);
    chk("w_lat", gl, 3);
    chk("w_err", 32'(ge), 0);
    run1(3'd1, 6'd39, 32'h0, gl, ge);
    chk("w_rd", bus1.rd_data, 32'hDEADBEEF);
    chk("w_rd_err", 32'(ge), 0);
    run1(3'd1, 6'd40, 32'h0, gl, ge);
    chk("w_oob_err", 32'(ge), 1);
    chk("w_oob_lat", gl, 2);
    chk("w_oob_rd", bus1.rd_data, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
